clk_pc_monitor: RTL

//  Receive-side checker for the divided PC clock produced by the clock divider.

---
 rtl/clk_pc_monitor.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/clk_pc_monitor.sv
// Receive-side checker for the divided PC clock: synchronizes clk_pc_in,
// emits edge strobes, measures half/full periods and tracks lock/fault.
module clk_pc_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8,
   parameter int EXP_HALF    = 4,
   parameter int TOL         = 0,
   parameter int LOCK_COUNT  = 4,
   parameter int TIMEOUT     = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_pc_in,
   input  logic             clear_err,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic [1:0]       state,
   output logic             err_glitch,
   output logic             err_slow,
   output logic             err_stall
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2,
      FAULT  = 2'd3
   } state_t;

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam logic [CNT_W-1:0] LO   = CNT_W'(EXP_HALF - TOL);
   localparam logic [CNT_W-1:0] HI   = CNT_W'(EXP_HALF + TOL);
   localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT - 1);
   localparam logic [GW-1:0]    LAST = GW'(LOCK_COUNT - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lvl;
   logic                   lvl_d;
   logic                   rise_det;
   logic                   fall_det;
   logic [CNT_W-1:0]       half_cnt;
   logic [CNT_W-1:0]       per_cnt;
   logic                   have_rise;
   logic [GW-1:0]          good_cnt;
   state_t                 st;
   logic                   strobe;
   logic                   short_h;
   logic                   long_h;
   logic                   good_h;
   logic                   timeout;
   logic                   clr_go;

   assign state    = st;
   assign rise_det = lvl & ~lvl_d;
   assign fall_det = ~lvl & lvl_d;
   assign strobe   = rise_pulse | fall_pulse;
   assign short_h  = half_cnt < LO;
   assign long_h   = half_cnt > HI;
   assign good_h   = ~short_h & ~long_h;
   assign timeout  = ~strobe & (half_cnt == TMO);
   assign clr_go   = clear_err & (st == FAULT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q     <= '0;
         lvl        <= 1'b0;
         lvl_d      <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], clk_pc_in};
         lvl        <= sync_q[SYNC_STAGES-1];
         lvl_d      <= lvl;
         rise_pulse <= rise_det;
         fall_pulse <= fall_det;
      end
   end

   // Runs one cycle ahead of the strobes so period lands with rise_pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         per_cnt      <= '0;
         have_rise    <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         period_valid <= rise_det & have_rise & ~clr_go;
         if (rise_det) begin
            if (have_rise && !clr_go) period <= per_cnt;
            per_cnt   <= CNT_W'(1);
            have_rise <= 1'b1;
         end else if (clr_go) begin
            per_cnt   <= '0;
            have_rise <= 1'b0;
         end else if (per_cnt != CMAX) begin
            per_cnt <= per_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         half_cnt   <= '0;
         good_cnt   <= '0;
         st         <= IDLE;
         locked     <= 1'b0;
         err_glitch <= 1'b0;
         err_slow   <= 1'b0;
         err_stall  <= 1'b0;
      end else begin
         if (clr_go) half_cnt <= '0;
         else if (strobe) half_cnt <= CNT_W'(1);
         else if (half_cnt != CMAX) half_cnt <= half_cnt + 1'b1;

         if (clr_go) begin
            st         <= IDLE;
            locked     <= 1'b0;
            good_cnt   <= '0;
            err_glitch <= 1'b0;
            err_slow   <= 1'b0;
            err_stall  <= 1'b0;
         end else begin
            if (timeout) err_stall <= 1'b1;
            unique case (st)
               IDLE: begin
                  if (strobe) begin
                     st       <= ACQ;
                     good_cnt <= '0;
                  end
               end
               ACQ: begin
                  if (timeout) begin
                     st <= FAULT;
                  end else if (strobe) begin
                     if (!good_h) begin
                        good_cnt <= '0;
                     end else if (good_cnt == LAST) begin
                        st     <= LOCKED;
                        locked <= 1'b1;
                     end else begin
                        good_cnt <= good_cnt + 1'b1;
                     end
                  end
               end
               LOCKED: begin
                  if (strobe && short_h) err_glitch <= 1'b1;
                  if (strobe && long_h) err_slow <= 1'b1;
                  if (timeout || (strobe && !good_h)) begin
                     st     <= FAULT;
                     locked <= 1'b0;
                  end
               end
               FAULT: begin
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
